// File: rtl/nn_pkg.sv
// Shared neural-layer definitions: default widths, responder state encoding and
// the saturating arithmetic helpers reused by later layers.
package nn_pkg;

   localparam int NN_DATA_W = 8;
   localparam int NN_ACC_W  = 24;
   localparam int NN_FRAC   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } nr_state_t;

   // Add two values and clamp the sum to the signed range of a width-bit word.
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      logic signed [63:0] sum;
      hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo  = -hi - 64'sd1;
      sum = a + b;
      if (sum > hi) return hi;
      if (sum < lo) return lo;
      return sum;
   endfunction

   // ReLU followed by clamping to the most positive value of a signed width-bit word.
   function automatic logic signed [63:0] relu_clamp(input logic signed [63:0] s,
                                                     input int width);
      logic signed [63:0] hi;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      if (s < 64'sd0) return 64'sd0;
      if (s > hi) return hi;
      return s;
   endfunction

endpackage

// File: rtl/sat_mac.sv
// Multiply-accumulate datapath: product register behind the memory read and a
// saturating accumulator that never wraps.
module sat_mac
   import nn_pkg::*;
#(
   parameter int DATA_W = NN_DATA_W,
   parameter int ACC_W  = NN_ACC_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rd_en,
   input  logic                    clear,
   input  logic [DATA_W-1:0]       mem_x,
   input  logic [DATA_W-1:0]       mem_w,
   output logic signed [ACC_W-1:0] acc
);

   localparam int PROD_W = 2 * DATA_W;

   logic                     rd_q;
   logic                     prod_valid;
   logic signed [PROD_W-1:0] prod_q;

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // the pre-edge values of the others, independent of statement order.
      if (rst) begin
         rd_q       <= 1'b0;
         prod_valid <= 1'b0;
         acc        <= '0;
      end else begin
         rd_q       <= rd_en;
         prod_valid <= rd_q;
         if (clear) begin
            acc <= '0;
         end else if (prod_valid) begin
            acc <= ACC_W'(sat_add(64'(acc), 64'(prod_q), ACC_W));
         end
      end
   end

   // Operand capture and multiply share one register so the product is added
   // two cycles after the read strobe.
   // NOTE: the product data register has no reset; prod_valid alone decides
   // whether it is used, so clearing the flag is enough to discard it.
   always_ff @(posedge clk) begin
      prod_q <= PROD_W'($signed(mem_x)) * PROD_W'($signed(mem_w));
   end

endmodule

// File: rtl/neuron_responder.sv
// Datapath side of the ld/index/ready handshake: one MAC per ld, and one
// ReLU-saturated output pulse per ready rising edge.
module neuron_responder
   import nn_pkg::*;
#(
   parameter int DATA_W = NN_DATA_W,
   parameter int ACC_W  = NN_ACC_W,
   parameter int ADDR_W = 16,
   parameter int FRAC   = NN_FRAC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld,
   input  logic [15:0]       index,
   input  logic              ready,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_x,
   input  logic [DATA_W-1:0] mem_w,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              busy
);

   nr_state_t               state;
   nr_state_t               state_nx;
   logic                    ready_q;
   logic                    ready_rise;
   logic                    drain_cnt;
   logic signed [ACC_W-1:0] acc;
   logic [DATA_W-1:0]       result;
   logic [DATA_W-1:0]       out_q;

   assign mem_addr   = index[ADDR_W-1:0];
   assign ready_rise = ready & ~ready_q;
   assign mem_rd_en  = ~rst & ld & ((state == IDLE) || (state == ACCUM));
   assign busy       = ~rst & (state != IDLE);
   assign out_valid  = ~rst & (state == DONE);

   // The final product lands in acc during DONE itself, so the result is formed
   // combinationally there and captured for holding afterwards.
   assign result   = DATA_W'(relu_clamp(64'(acc) >>> FRAC, DATA_W));
   assign out_data = out_valid ? result : out_q;

   always_comb begin
      // NOTE: state_nx gets a default before the case so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_nx = state;
      case (state)
         IDLE: begin
            if (ready_rise)  state_nx = DRAIN;
            else if (ld)     state_nx = ACCUM;
         end
         ACCUM: if (ready_rise) state_nx = DRAIN;
         DRAIN: if (drain_cnt)  state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ready_q   <= 1'b0;
         drain_cnt <= 1'b0;
         out_q     <= '0;
      end else begin
         state     <= state_nx;
         ready_q   <= ready;
         drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
         if (state == DONE) out_q <= result;
      end
   end

   sat_mac #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk   (clk),
      .rst   (rst),
      .rd_en (mem_rd_en),
      .clear (state == DONE),
      .mem_x (mem_x),
      .mem_w (mem_w),
      .acc   (acc)
   );

endmodule

// File: tb/tb_neuron_responder.sv
// Drives three responder configurations from one shared memory model and checks
// each result against a sequence-level reference model.
module tb_neuron_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld;
   logic [15:0] index;
   logic        ready;
   logic [7:0]  mem_x;
   logic [7:0]  mem_w;

   logic        rd_en_a, rd_en_b, rd_en_c;
   logic [15:0] addr_a, addr_b, addr_c;
   logic [7:0]  out_a, out_b, out_c;
   logic        valid_a, valid_b, valid_c;
   logic        busy_a, busy_b, busy_c;

   logic [7:0]  xm [65536];
   logic [7:0]  wm [65536];

   int          px[$];
   int          pw[$];
   int          pidx[$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   neuron_responder #(.DATA_W(8), .ACC_W(24), .ADDR_W(16), .FRAC(0)) dut_a (
      .clk(clk), .rst(rst), .ld(ld), .index(index), .ready(ready),
      .mem_rd_en(rd_en_a), .mem_addr(addr_a), .mem_x(mem_x), .mem_w(mem_w),
      .out_data(out_a), .out_valid(valid_a), .busy(busy_a));

   neuron_responder #(.DATA_W(8), .ACC_W(24), .ADDR_W(16), .FRAC(4)) dut_b (
      .clk(clk), .rst(rst), .ld(ld), .index(index), .ready(ready),
      .mem_rd_en(rd_en_b), .mem_addr(addr_b), .mem_x(mem_x), .mem_w(mem_w),
      .out_data(out_b), .out_valid(valid_b), .busy(busy_b));

   neuron_responder #(.DATA_W(8), .ACC_W(16), .ADDR_W(16), .FRAC(0)) dut_c (
      .clk(clk), .rst(rst), .ld(ld), .index(index), .ready(ready),
      .mem_rd_en(rd_en_c), .mem_addr(addr_c), .mem_x(mem_x), .mem_w(mem_w),
      .out_data(out_c), .out_valid(valid_c), .busy(busy_c));

   // Synchronous-read memory: data appears the cycle after the strobe.
   always @(posedge clk) begin
      if (rd_en_a) begin
         mem_x <= xm[addr_a];
         mem_w <= wm[addr_a];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic signed [63:0] observed,
                        input logic signed [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Sum of products of the programmed sequence, clamped after every addition.
   function automatic longint model_acc(input int acc_w);
      longint hi = (longint'(1) << (acc_w - 1)) - 1;
      longint lo = -hi - 1;
      longint a  = 0;
      foreach (px[i]) begin
         a = a + longint'(px[i]) * longint'(pw[i]);
         if (a > hi) a = hi;
         if (a < lo) a = lo;
      end
      return a;
   endfunction

   function automatic longint model_out(input int acc_w, input int frac);
      longint s = model_acc(acc_w) >>> frac;
      if (s < 0) return 0;
      if (s > 127) return 127;
      return s;
   endfunction

   task automatic prog_clear();
      px.delete();
      pw.delete();
      pidx.delete();
   endtask

   task automatic prog_add(input int idx, input int x, input int w);
      pidx.push_back(idx);
      px.push_back(x);
      pw.push_back(w);
   endtask

   // Issue the programmed lds, raise ready after `gap` idle cycles (0 = with the
   // last ld), then check the drain/done timing and the three results.
   task automatic run(input string tag, input int gap, input bit hold, input bit ld_drain);
      int     n = px.size();
      int     pulses = 0;
      longint exp_a, exp_b, exp_c;
      ld    = 1'b0;
      ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         xm[pidx[i]] = 8'(px[i]);
         wm[pidx[i]] = 8'(pw[i]);
         ld    = 1'b1;
         index = 16'(pidx[i]);
         #1;
         check({tag, " rd_en"}, {rd_en_a, rd_en_b, rd_en_c}, 3'b111);
         check({tag, " addr"}, addr_c, pidx[i]);
         if (i != n - 1 || gap != 0) step();
      end
      if (gap != 0) begin
         ld = 1'b0;
         repeat (gap - 1) step();
      end
      ready = 1'b1;
      exp_a = model_out(24, 0);
      exp_b = model_out(24, 4);
      exp_c = model_out(16, 0);
      for (int k = 1; k <= 2; k++) begin
         step();
         ld    = ld_drain;
         index = 16'($urandom);
         #1;
         check({tag, " drain rd_en"}, {rd_en_a, rd_en_b, rd_en_c}, 3'b000);
         check({tag, " drain valid"}, {valid_a, valid_b, valid_c}, 3'b000);
         check({tag, " drain busy"}, {busy_a, busy_b, busy_c}, 3'b111);
      end
      step();
      ld = 1'b0;
      check({tag, " done valid"}, {valid_a, valid_b, valid_c}, 3'b111);
      check({tag, " out_a"}, out_a, exp_a);
      check({tag, " out_b"}, out_b, exp_b);
      check({tag, " out_c"}, out_c, exp_c);
      check({tag, " acc_a"}, dut_a.u_mac.acc, model_acc(24));
      check({tag, " acc_c"}, dut_c.u_mac.acc, model_acc(16));
      if (!hold) ready = 1'b0;
      step();
      check({tag, " after valid"}, {valid_a, valid_b, valid_c}, 3'b000);
      check({tag, " after busy"}, {busy_a, busy_b, busy_c}, 3'b000);
      check({tag, " held out_a"}, out_a, exp_a);
      if (hold) begin
         repeat (10) begin
            step();
            pulses += int'(valid_a) + int'(valid_b) + int'(valid_c);
         end
         check({tag, " extra pulses"}, pulses, 0);
         ready = 1'b0;
         step();
      end
   endtask

   initial begin
      rst   = 1'b1;
      ld    = 1'b1;
      index = 16'd5;
      ready = 1'b0;
      foreach (xm[i]) begin
         xm[i] = 8'($urandom);
         wm[i] = 8'($urandom);
      end
      #1;
      check("reset rd_en", {rd_en_a, rd_en_b, rd_en_c}, 3'b000);
      check("reset busy", {busy_a, busy_b, busy_c}, 3'b000);
      step();
      check("reset valid", {valid_a, valid_b, valid_c}, 3'b000);
      check("reset out", {out_a, out_b, out_c}, 24'd0);
      rst = 1'b0;
      ld  = 1'b0;
      step();

      prog_clear();
      prog_add(0, 1, 4);
      prog_add(1, 2, 5);
      prog_add(2, 3, 6);
      run("dot32", 1, 1'b0, 1'b1);

      prog_clear();
      prog_add(10, -5, 10);
      prog_add(11, -5, 10);
      run("relu", 0, 1'b0, 1'b0);

      prog_clear();
      for (int i = 0; i < 64; i++) prog_add(100 + i, 127, 127);
      run("sat_pos", 1, 1'b0, 1'b0);

      prog_clear();
      for (int i = 0; i < 64; i++) prog_add(400 + i, -128, 127);
      run("sat_neg", 2, 1'b0, 1'b0);

      prog_clear();
      for (int i = 0; i < 40; i++) prog_add(600 + i, 127, 127);
      run("sat_out", 1, 1'b0, 1'b0);

      // Abort a run mid-accumulation; nothing from it may survive.
      ld = 1'b1; index = 16'd200; xm[200] = 8'd50; wm[200] = 8'd50;
      step();
      index = 16'd201; xm[201] = 8'd50; wm[201] = 8'd50;
      step();
      rst = 1'b1;
      #1;
      check("rst mid rd_en", {rd_en_a, rd_en_b, rd_en_c}, 3'b000);
      check("rst mid busy", {busy_a, busy_b, busy_c}, 3'b000);
      step();
      check("rst mid out", {out_a, out_b, out_c}, 24'd0);
      check("rst mid acc", dut_a.u_mac.acc, 0);
      rst = 1'b0;
      ld  = 1'b0;
      step();
      prog_clear();
      prog_add(300, 1, 3);
      run("after_rst", 1, 1'b0, 1'b0);

      prog_clear();
      run("no_ld_hold", 1, 1'b1, 1'b0);

      for (int r = 0; r < 25; r++) begin
         int n = int'($urandom_range(0, 12));
         prog_clear();
         for (int i = 0; i < n; i++) begin
            prog_add(int'($urandom_range(0, 65535)),
                     int'($urandom_range(0, 255)) - 128,
                     int'($urandom_range(0, 255)) - 128);
         end
         run("random", int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/neuron_responder.md
# neuron_responder

Datapath end of the controller's `ld`/`index`/`ready` sequencing interface. For each `ld` pulse it fetches the input and weight at `index` from a synchronous memory, multiplies them, and accumulates the product. When the controller raises `ready` (sequence finished), it drains its pipeline and emits one ReLU-and-saturated neuron output with a single-cycle `out_valid`. It sits between the controller and the next layer's input buffer.

## Interface
- `DATA_W`, 8: signed width of input and weight words; also the output width.
- `ACC_W`, 24: signed accumulator width.
- `ADDR_W`, 16: memory address width, taken from the low bits of `index`.
- `FRAC`, 4: arithmetic right shift applied to the accumulator before output.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ld` in 1: `index` is valid this cycle; one MAC is requested.
- `index` in 16: element index from the controller.
- `ready` in 1: controller sequence complete; only its rising edge is acted on.
- `mem_rd_en` out 1: memory read strobe; equals `ld` while in IDLE/ACCUM.
- `mem_addr` out ADDR_W: `index[ADDR_W-1:0]`, combinational.
- `mem_x` in DATA_W: signed input word, valid the cycle after `mem_rd_en`.
- `mem_w` in DATA_W: signed weight word, valid the cycle after `mem_rd_en`.
- `out_data` out DATA_W: neuron result, held until the next result.
- `out_valid` out 1: one-cycle pulse when `out_data` updates.
- `busy` out 1: high in ACCUM, DRAIN and DONE.

## Operation
- **States:**
  - IDLE: `ld` moves to ACCUM.
  - ACCUM: a `ready` rising edge moves to DRAIN.
  - DRAIN: 2 cycles, then DONE.
  - DONE: 1 cycle, then IDLE.
  - A `ready` rising edge in IDLE with no prior `ld` goes straight to DRAIN and produces result 0.
- **Pipeline:**
  - Stage 0 (cycle t): `ld` issues the read.
  - Stage 1 (t+1): registers `mem_x` and `mem_w` along with a valid bit.
  - Stage 2 (t+2): registers the signed product (2·DATA_W bits) with a valid bit.
  - Accumulate: at the end of t+2, the sign-extended product is added to `acc`.
- **Accumulator:**
  - Saturating: clamps to the most positive or most negative ACC_W value, never wraps.
  - Cleared in DONE.
- **Output (in DONE):**
  - s = `acc` >>> FRAC.
  - `out_data` = 0 if s < 0; 2^(DATA_W-1)-1 if s exceeds it; otherwise s.
  - `out_valid` = 1 for that cycle.
- **Ignored inputs:**
  - `ld` in DRAIN or DONE: no read is issued, `mem_rd_en` = 0.
  - `ready` while already DRAIN or DONE: ignored.
  - `ready` held high: produces only one result.
- **Index range:** bits of `index` at or above ADDR_W are dropped, so addresses wrap modulo 2^ADDR_W.
- **Reset:**
  - `acc`, pipeline valid bits, the `ready` edge register, `out_data` and `out_valid` clear to 0; state goes to IDLE.
  - In-flight products are discarded.
  - `busy` = 0 and `mem_rd_en` = 0 while `rst` is high.

## Timing
- Reset values: `out_data` 0, `out_valid` 0, `busy` 0, `mem_rd_en` 0 (combinational from `ld` outside reset).
- Read latency: 1 cycle. `ld` to accumulator update: 3 cycles, with `acc` visible at t+3.
- Throughput: one `ld` per cycle, back-to-back, with no stalls.
- The controller guarantees the last `ld` occurs before the `ready` rise.
- `ready` rising edge detected at cycle r (registered compare): DRAIN spans r+1 and r+2, DONE and `out_valid` occur at r+3.
- `ld` at r-1 is therefore included in the result.
- A new `ld` is accepted from r+4 onward.
- `ld` arriving in the same cycle as the `ready` edge (state ACCUM): the read is issued and included.

## Structure
- Shared package `nn_pkg`:
  - DATA_W, ACC_W and FRAC defaults.
  - State encoding `nr_state_t` {IDLE, ACCUM, DRAIN, DONE}.
  - The saturating add and the ReLU clamp functions, reused by later layers.
- One sub-module, `sat_mac`: product register, sign extension, saturating accumulate and clear. It has parameters DATA_W and ACC_W.
- The FSM, `ready` edge detect and output register stay in `neuron_responder`.

## Test plan
- FRAC=0. `ld` indices 0,1,2 back-to-back with x={1,2,3}, w={4,5,6}, then `ready` rises. Expect `out_data`=32 with a single `out_valid` at edge+3, and `busy` low the next cycle.
- x={-5,-5}, w={10,10}. Expect `out_data`=0 (ReLU).
- FRAC=4. 64 lds of x=127, w=127: acc=1032256, s=64516. Expect `out_data`=127 (saturated).
- Accumulator saturation: ACC_W=16 with products pushing the sum above 32767. Expect `acc`=32767, not a wrapped negative value.
- `ready` rise with no `ld`. Expect `out_data`=0 and `out_valid` pulse. Hold `ready` high for 10 cycles: expect exactly one pulse.
- `rst` asserted mid-ACCUM after 2 lds, then a fresh run of x={1}, w={3}. Expect `out_data`=3, with no residue from the aborted run.
